mem_responder: RTL and testbench

MEM_RESPONDER -- requirements
Module: mem_responder

---
 rtl/mem_responder_pkg.sv | 24 ++
 rtl/mem_responder_beat_store.sv | 32 +++
 rtl/mem_responder.sv | 121 ++++++++++++
 tb/tb_mem_responder.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/mem_responder_pkg.sv
// Shared widths and helpers for the memory responder and its beat store.
package mem_responder_pkg;

    localparam int unsigned MEM_DATA_BITS  = 128;
    localparam int unsigned CPU_ADDR_BITS  = 32;
    localparam int unsigned BEAT_ADDR_BITS = CPU_ADDR_BITS - 2 - 2;
    localparam int unsigned MASK_BITS      = MEM_DATA_BITS / 8;
    localparam int unsigned LAT_W          = 4;

    typedef logic [MEM_DATA_BITS-1:0] beat_t;

    // Smallest r with 2**r >= v.
    function automatic int unsigned ceil_log2(input int unsigned v);
        int unsigned r;
        r = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if ((64'(1) << i) < 64'(v)) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/mem_responder_beat_store.sv
// DEPTH x 128-bit beat storage: one byte-masked write port, one asynchronous read port.
module mem_beat_store
    import mem_responder_pkg::*;
#(
    parameter int unsigned DEPTH = 1024,
    parameter int unsigned IDX_W = ceil_log2(DEPTH)
) (
    input  logic                 clk_i,
    input  logic                 we_i,
    input  logic [IDX_W-1:0]     waddr_i,
    input  beat_t                wdata_i,
    input  logic [MASK_BITS-1:0] wmask_i,
    input  logic [IDX_W-1:0]     raddr_i,
    output beat_t                rdata_o
);

    beat_t mem_q [DEPTH];

    // Contents are intentionally not reset.
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            for (int b = 0; b < int'(MASK_BITS); b++) begin
                if (wmask_i[b]) begin
                    mem_q[waddr_i][8*b +: 8] <= wdata_i[8*b +: 8];
                end
            end
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/mem_responder.sv
// Fixed-latency memory model: masked single-beat writes, 4-beat aligned read bursts.
module mem_responder
    import mem_responder_pkg::*;
#(
    parameter int unsigned DEPTH   = 1024,
    parameter int unsigned LATENCY = 4
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      mem_req_valid,
    output logic                      mem_req_ready,
    input  logic [BEAT_ADDR_BITS-1:0] mem_req_addr,
    input  logic                      mem_req_rw,
    input  logic                      mem_req_data_valid,
    output logic                      mem_req_data_ready,
    input  logic [MEM_DATA_BITS-1:0]  mem_req_data_bits,
    input  logic [MASK_BITS-1:0]      mem_req_data_mask,
    output logic                      mem_resp_valid,
    output logic [MEM_DATA_BITS-1:0]  mem_resp_data
);

    localparam int unsigned IDX_W = ceil_log2(DEPTH);
    localparam int unsigned GRP_W = IDX_W - 2;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WAIT  = 2'd1,
        ST_BURST = 2'd2
    } state_e;

    state_e             state_q, state_d;
    logic [LAT_W-1:0]   lat_q, lat_d;
    logic [1:0]         beat_q, beat_d;
    logic [GRP_W-1:0]   grp_q, grp_d;

    logic               idle_c;
    logic               wr_en_c;
    logic [IDX_W-1:0]   raddr_c;
    beat_t              rdata_c;

    // Bits above the storage index alias; only the low IDX_W bits matter.
    logic unused_addr;
    assign unused_addr = ^mem_req_addr;

    assign idle_c  = (state_q == ST_IDLE) && !reset;
    assign wr_en_c = idle_c && mem_req_valid && mem_req_rw && mem_req_data_valid;
    assign raddr_c = {grp_q, beat_q};

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            lat_q   <= '0;
            beat_q  <= '0;
            grp_q   <= '0;
        end else begin
            state_q <= state_d;
            lat_q   <= lat_d;
            beat_q  <= beat_d;
            grp_q   <= grp_d;
        end
    end

    always_comb begin
        state_d = state_q;
        lat_d   = lat_q;
        beat_d  = beat_q;
        grp_d   = grp_q;
        case (state_q)
            ST_IDLE: begin
                if (mem_req_valid && !mem_req_rw) begin
                    grp_d  = mem_req_addr[IDX_W-1:2];
                    beat_d = '0;
                    if (LATENCY <= 1) begin
                        lat_d   = '0;
                        state_d = ST_BURST;
                    end else begin
                        lat_d   = LAT_W'(LATENCY - 1);
                        state_d = ST_WAIT;
                    end
                end
            end
            ST_WAIT: begin
                // Entering BURST on the cycle the counter reaches zero.
                if (lat_q <= LAT_W'(1)) begin
                    lat_d   = '0;
                    state_d = ST_BURST;
                end else begin
                    lat_d = lat_q - LAT_W'(1);
                end
            end
            ST_BURST: begin
                beat_d = beat_q + 2'd1;
                if (beat_q == 2'd3) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    mem_beat_store #(
        .DEPTH (DEPTH),
        .IDX_W (IDX_W)
    ) u_store (
        .clk_i   (clk),
        .we_i    (wr_en_c),
        .waddr_i (mem_req_addr[IDX_W-1:0]),
        .wdata_i (mem_req_data_bits),
        .wmask_i (mem_req_data_mask),
        .raddr_i (raddr_c),
        .rdata_o (rdata_c)
    );

    assign mem_req_ready      = idle_c;
    assign mem_req_data_ready = idle_c;
    assign mem_resp_valid     = (state_q == ST_BURST) && !reset;
    assign mem_resp_data      = mem_resp_valid ? rdata_c : '0;

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder: LATENCY=4 instance plus a LATENCY=1 instance.
module tb_mem_responder;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // Instance A: default parameters.
    logic         reset, req_valid, req_ready, req_rw, dvalid, dready, resp_valid;
    logic [27:0]  req_addr;
    logic [127:0] dbits, resp_data;
    logic [15:0]  dmask;

    // Instance B: LATENCY = 1.
    logic         b_reset, b_valid, b_ready, b_rw, b_dvalid, b_dready, b_resp_valid;
    logic [27:0]  b_addr;
    logic [127:0] b_dbits, b_resp_data;
    logic [15:0]  b_dmask;

    mem_responder #(.DEPTH(1024), .LATENCY(4)) dut (
        .clk                (clk),
        .reset              (reset),
        .mem_req_valid      (req_valid),
        .mem_req_ready      (req_ready),
        .mem_req_addr       (req_addr),
        .mem_req_rw         (req_rw),
        .mem_req_data_valid (dvalid),
        .mem_req_data_ready (dready),
        .mem_req_data_bits  (dbits),
        .mem_req_data_mask  (dmask),
        .mem_resp_valid     (resp_valid),
        .mem_resp_data      (resp_data)
    );

    mem_responder #(.DEPTH(1024), .LATENCY(1)) dut_l1 (
        .clk                (clk),
        .reset              (b_reset),
        .mem_req_valid      (b_valid),
        .mem_req_ready      (b_ready),
        .mem_req_addr       (b_addr),
        .mem_req_rw         (b_rw),
        .mem_req_data_valid (b_dvalid),
        .mem_req_data_ready (b_dready),
        .mem_req_data_bits  (b_dbits),
        .mem_req_data_mask  (b_dmask),
        .mem_resp_valid     (b_resp_valid),
        .mem_resp_data      (b_resp_data)
    );

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_write(input logic [27:0] a, input logic [127:0] d, input logic [15:0] m);
        req_valid = 1'b1; req_rw = 1'b1; dvalid = 1'b1;
        req_addr = a; dbits = d; dmask = m;
        cyc();
        req_valid = 1'b0; dvalid = 1'b0;
    endtask

    // Issue a read in cycle N and check ready/valid/data through cycle N+8.
    task automatic run_read(input string tag, input logic [27:0] a,
                            input logic [127:0] e0, input logic [127:0] e1,
                            input logic [127:0] e2, input logic [127:0] e3,
                            input logic [3:0] cm);
        logic [127:0] e [4];
        e[0] = e0; e[1] = e1; e[2] = e2; e[3] = e3;
        chk({tag, "_ready_N"}, 128'(req_ready), 128'd1);
        req_valid = 1'b1; req_rw = 1'b0; req_addr = a;
        cyc();
        req_valid = 1'b0;
        for (int k = 1; k < 4; k++) begin
            chk({tag, "_wait_ready"}, 128'(req_ready), 128'd0);
            chk({tag, "_wait_valid"}, 128'(resp_valid), 128'd0);
            chk({tag, "_wait_data0"}, resp_data, 128'd0);
            cyc();
        end
        for (int b = 0; b < 4; b++) begin
            chk({tag, "_beat_valid"}, 128'(resp_valid), 128'd1);
            chk({tag, "_beat_ready"}, 128'(req_ready), 128'd0);
            if (cm[b]) chk({tag, $sformatf("_beat%0d_data", b)}, resp_data, e[b]);
            cyc();
        end
        chk({tag, "_ready_N8"}, 128'(req_ready), 128'd1);
        chk({tag, "_valid_N8"}, 128'(resp_valid), 128'd0);
    endtask

    // LATENCY=1 read: beats in N+1..N+4, ready again in N+5.
    task automatic b_read(input string tag, input logic [27:0] a, input logic [127:0] e1);
        chk({tag, "_ready_N"}, 128'(b_ready), 128'd1);
        b_valid = 1'b1; b_rw = 1'b0; b_addr = a;
        cyc();
        b_valid = 1'b0;
        for (int b = 0; b < 4; b++) begin
            chk({tag, "_beat_valid"}, 128'(b_resp_valid), 128'd1);
            if (b == 1) chk({tag, "_beat1_data"}, b_resp_data, e1);
            cyc();
        end
        chk({tag, "_ready_N5"}, 128'(b_ready), 128'd1);
        chk({tag, "_valid_N5"}, 128'(b_resp_valid), 128'd0);
    endtask

    initial begin
        logic [127:0] v [8];
        reset = 1'b1; req_valid = 1'b1; req_rw = 1'b0; dvalid = 1'b0;
        req_addr = '0; dbits = '0; dmask = '0;
        b_reset = 1'b1; b_valid = 1'b0; b_rw = 1'b0; b_dvalid = 1'b0;
        b_addr = '0; b_dbits = '0; b_dmask = '0;

        // Reset gating of outputs, even with a request pending.
        cyc();
        chk("rst_ready", 128'(req_ready), 128'd0);
        chk("rst_dready", 128'(dready), 128'd0);
        chk("rst_valid", 128'(resp_valid), 128'd0);
        chk("rst_data", resp_data, 128'd0);
        cyc();
        reset = 1'b0; b_reset = 1'b0; req_valid = 1'b0;
        #1;
        chk("idle_ready", 128'(req_ready), 128'd1);
        chk("idle_dready", 128'(dready), 128'd1);
        chk("idle_valid", 128'(resp_valid), 128'd0);
        cyc();

        // Byte-masked overwrite, then read the group from an unaligned address.
        do_write(28'h10, 128'h00112233_44556677_8899AABB_CCDDEEFF, 16'hFFFF);
        do_write(28'h10, {128{1'b1}}, 16'h000F);
        run_read("mask", 28'h12, 128'h00112233_44556677_8899AABB_FFFFFFFF,
                 '0, '0, '0, 4'b0001);

        // Burst order starts at the aligned base regardless of addr[1:0].
        for (int i = 0; i < 4; i++) do_write(28'(28'h20 + i), 128'(i + 1), 16'hFFFF);
        run_read("order", 28'h23, 128'd1, 128'd2, 128'd3, 128'd4, 4'b1111);

        // Eight back-to-back writes with ready held high.
        req_valid = 1'b1; req_rw = 1'b1; dvalid = 1'b1; dmask = 16'hFFFF;
        for (int i = 0; i < 8; i++) begin
            v[i] = {4{32'(32'hA5000000 + i)}};
            chk("b2b_ready", 128'(req_ready), 128'd1);
            req_addr = 28'(28'h40 + i); dbits = v[i];
            cyc();
        end
        req_valid = 1'b0; dvalid = 1'b0;
        run_read("b2b_lo", 28'h40, v[0], v[1], v[2], v[3], 4'b1111);
        run_read("b2b_hi", 28'h45, v[4], v[5], v[6], v[7], 4'b1111);

        // Reset during the second burst beat aborts the burst.
        req_valid = 1'b1; req_rw = 1'b0; req_addr = 28'h20;
        cyc();
        req_valid = 1'b0;
        cyc(); cyc(); cyc();
        chk("abort_beat0", 128'(resp_valid), 128'd1);
        cyc();
        reset = 1'b1;
        #1;
        chk("abort_valid", 128'(resp_valid), 128'd0);
        chk("abort_data", resp_data, 128'd0);
        chk("abort_ready", 128'(req_ready), 128'd0);
        cyc();
        reset = 1'b0;
        #1;
        for (int k = 0; k < 5; k++) begin
            chk("post_abort_valid", 128'(resp_valid), 128'd0);
            chk("post_abort_ready", 128'(req_ready), 128'd1);
            cyc();
        end

        // Aliasing modulo DEPTH, and a write without data is ignored.
        do_write(28'h001, 128'hDEAD_0001, 16'hFFFF);
        do_write(28'h400, 128'hBEEF_0400, 16'hFFFF);
        req_valid = 1'b1; req_rw = 1'b1; dvalid = 1'b0;
        req_addr = 28'h001; dbits = 128'h5555; dmask = 16'hFFFF;
        cyc();
        chk("nodata_ready", 128'(req_ready), 128'd1);
        cyc();
        chk("nodata_valid", 128'(resp_valid), 128'd0);
        req_valid = 1'b0;
        run_read("alias", 28'h000, 128'hBEEF_0400, 128'hDEAD_0001, '0, '0, 4'b0011);

        // LATENCY=1 instance: back-to-back reads accepted in N and N+5.
        b_valid = 1'b1; b_rw = 1'b1; b_dvalid = 1'b1;
        b_addr = 28'h5; b_dbits = 128'h55; b_dmask = 16'hFFFF;
        cyc();
        b_valid = 1'b0; b_dvalid = 1'b0;
        b_read("lat1_a", 28'h4, 128'h55);
        b_read("lat1_b", 28'h7, 128'h55);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
